// File: rtl/ball_motion_if.sv
// Per-ball bus: frame/collision/cue/pocket controls in, position/velocity/status out.
interface ball_motion_if;
   logic               startOfFrame;
   logic               collisionOccurred;
   logic signed [10:0] velXIn, velYIn;
   logic               strike;
   logic signed [10:0] strikeVelX, strikeVelY;
   logic               pocketDR;
   logic               respawn;
   logic signed [10:0] topLeftX, topLeftY;
   logic signed [10:0] velX, velY;
   logic               ballMoving;
   logic               ballPocketed;

   modport master (
      output startOfFrame, collisionOccurred, velXIn, velYIn,
             strike, strikeVelX, strikeVelY, pocketDR, respawn,
      input  topLeftX, topLeftY, velX, velY, ballMoving, ballPocketed
   );

   modport slave (
      input  startOfFrame, collisionOccurred, velXIn, velYIn,
             strike, strikeVelX, strikeVelY, pocketDR, respawn,
      output topLeftX, topLeftY, velX, velY, ballMoving, ballPocketed
   );
endinterface

// File: rtl/ball_motion.sv
// One ball's fixed-point position/velocity: latches events mid-frame, applies them at startOfFrame.
// Optional velocity saturation on strike/collision load: BALL_MOTION_SPEED_CLAMP_EN.
module ball_motion #(
   parameter int INIT_X          = 320,
   parameter int INIT_Y          = 240,
   parameter int FRAC_BITS       = 4,
   parameter int FRICTION_PERIOD = 8,
   parameter int MAX_SPEED       = 256
) (
   input logic         clk,
   input logic         resetN,
   ball_motion_if.slave bus
);
   localparam int ACC_W = 11 + FRAC_BITS;
   localparam int FCW   = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
   localparam logic signed [ACC_W-1:0] INIT_AX = ACC_W'(INIT_X) << FRAC_BITS;
   localparam logic signed [ACC_W-1:0] INIT_AY = ACC_W'(INIT_Y) << FRAC_BITS;
   localparam logic [FCW-1:0]          FCNT_LAST = FCW'(FRICTION_PERIOD - 1);
`ifdef BALL_MOTION_SPEED_CLAMP_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, MOVING, POCKETED} state_t;

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  accx_q, accy_q, accx_d, accy_d;
   logic signed [10:0]       velx_q, vely_q, velx_d, vely_d;
   logic [FCW-1:0]           fcnt_q, fcnt_d;
   logic                     col_q, stk_q, pkt_q, rsp_q;
   logic signed [10:0]       colx_q, coly_q, stkx_q, stky_q;
   logic                     ld_init;

   function automatic logic signed [10:0] load_vel(input logic signed [10:0] v);
      int vi;
      vi = int'(v);
      if (!CLAMP_EN)            return v;
      else if (vi > MAX_SPEED)  return 11'(MAX_SPEED);
      else if (vi < -MAX_SPEED) return 11'(-MAX_SPEED);
      else                      return v;
   endfunction

   function automatic logic signed [10:0] decay(input logic signed [10:0] v);
      if (v > 0)      return v - 11'sd1;
      else if (v < 0) return v + 11'sd1;
      else            return v;
   endfunction

   always_comb begin
      state_d = state_q;
      velx_d  = velx_q;
      vely_d  = vely_q;
      fcnt_d  = fcnt_q;
      ld_init = 1'b0;
      case (state_q)
         MOVING: begin
            if (pkt_q) begin
               state_d = POCKETED;
               velx_d  = '0;
               vely_d  = '0;
            end else if (col_q) begin
               velx_d = load_vel(colx_q);
               vely_d = load_vel(coly_q);
               fcnt_d = '0;
            end else if (fcnt_q == FCNT_LAST) begin
               velx_d = decay(velx_q);
               vely_d = decay(vely_q);
               fcnt_d = '0;
            end else begin
               fcnt_d = fcnt_q + 1'b1;
            end
         end
         IDLE: begin
            if (stk_q) begin
               velx_d = load_vel(stkx_q);
               vely_d = load_vel(stky_q);
               fcnt_d = '0;
            end
         end
         POCKETED: begin
            if (rsp_q) begin
               state_d = IDLE;
               ld_init = 1'b1;
               velx_d  = '0;
               vely_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      // Outside pocketing, motion status is purely "is the selected velocity nonzero".
      if (state_q == IDLE || (state_q == MOVING && !pkt_q))
         state_d = (velx_d != 0 || vely_d != 0) ? MOVING : IDLE;
      if (state_d != MOVING) fcnt_d = '0;

      if (ld_init) begin
         accx_d = INIT_AX;
         accy_d = INIT_AY;
      end else if (state_d == MOVING) begin
         accx_d = accx_q + {{FRAC_BITS{velx_d[10]}}, velx_d};
         accy_d = accy_q + {{FRAC_BITS{vely_d[10]}}, vely_d};
      end else begin
         accx_d = accx_q;
         accy_d = accy_q;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         accx_q  <= INIT_AX;
         accy_q  <= INIT_AY;
         velx_q  <= '0;
         vely_q  <= '0;
         fcnt_q  <= '0;
         col_q   <= 1'b0;
         colx_q  <= '0;
         coly_q  <= '0;
         stk_q   <= 1'b0;
         stkx_q  <= '0;
         stky_q  <= '0;
         pkt_q   <= 1'b0;
         rsp_q   <= 1'b0;
      end else begin
         // On the SOF cycle pending latches are consumed; a coincident event opens the next frame.
         if (bus.collisionOccurred && (bus.startOfFrame || !col_q)) begin
            colx_q <= bus.velXIn;
            coly_q <= bus.velYIn;
         end
         col_q <= bus.startOfFrame ? bus.collisionOccurred : (col_q | bus.collisionOccurred);

         if (bus.strike && state_q == IDLE && (bus.startOfFrame || !stk_q)) begin
            stkx_q <= bus.strikeVelX;
            stky_q <= bus.strikeVelY;
         end
         stk_q <= (bus.startOfFrame ? 1'b0 : stk_q) | (bus.strike && state_q == IDLE);

         pkt_q <= (bus.startOfFrame ? 1'b0 : pkt_q) | bus.pocketDR;
         rsp_q <= (bus.startOfFrame ? 1'b0 : rsp_q) | (bus.respawn && state_q == POCKETED);

         if (bus.startOfFrame) begin
            state_q <= state_d;
            velx_q  <= velx_d;
            vely_q  <= vely_d;
            accx_q  <= accx_d;
            accy_q  <= accy_d;
            fcnt_q  <= fcnt_d;
         end
      end
   end

   assign bus.topLeftX     = accx_q[FRAC_BITS +: 11];
   assign bus.topLeftY     = accy_q[FRAC_BITS +: 11];
   assign bus.velX         = velx_q;
   assign bus.velY         = vely_q;
   assign bus.ballMoving   = (state_q == MOVING);
   assign bus.ballPocketed = (state_q == POCKETED);
endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: one instance with friction every frame, one with the default period.
module tb_ball_motion;
   logic clk = 1'b0;
   logic resetN;
   int   n_cmp = 0;
   int   n_err = 0;

   ball_motion_if bus();
   ball_motion_if bus8();

   ball_motion #(.FRICTION_PERIOD(1)) dut  (.clk(clk), .resetN(resetN), .bus(bus.slave));
   ball_motion                        dut8 (.clk(clk), .resetN(resetN), .bus(bus8.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sof();
      bus.startOfFrame  = 1'b1;
      bus8.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame  = 1'b0;
      bus8.startOfFrame = 1'b0;
   endtask

   task automatic do_strike(input int vx, input int vy);
      bus.strike = 1'b1; bus.strikeVelX = 11'(vx); bus.strikeVelY = 11'(vy);
      tick();
      bus.strike = 1'b0;
   endtask

   task automatic do_col(input int vx, input int vy);
      bus.collisionOccurred = 1'b1; bus.velXIn = 11'(vx); bus.velYIn = 11'(vy);
      tick();
      bus.collisionOccurred = 1'b0;
   endtask

   task automatic pulse_pocket();
      bus.pocketDR = 1'b1; tick(); bus.pocketDR = 1'b0;
   endtask

   task automatic pulse_respawn();
      bus.respawn = 1'b1; tick(); bus.respawn = 1'b0;
   endtask

   initial begin
      resetN = 1'b0;
      bus.startOfFrame = 0; bus.collisionOccurred = 0; bus.velXIn = 0; bus.velYIn = 0;
      bus.strike = 0; bus.strikeVelX = 0; bus.strikeVelY = 0; bus.pocketDR = 0; bus.respawn = 0;
      bus8.startOfFrame = 0; bus8.collisionOccurred = 0; bus8.velXIn = 0; bus8.velYIn = 0;
      bus8.strike = 0; bus8.strikeVelX = 0; bus8.strikeVelY = 0; bus8.pocketDR = 0; bus8.respawn = 0;
      tick(); tick();
      chk("rst_x", bus.topLeftX, 320);
      chk("rst_y", bus.topLeftY, 240);
      chk("rst_vx", bus.velX, 0);
      chk("rst_vy", bus.velY, 0);
      chk("rst_mov", bus.ballMoving, 0);
      chk("rst_pkt", bus.ballPocketed, 0);
      resetN = 1'b1;
      tick();

      // default friction period: strike (3,0), first decay on the 8th frame after the strike frame
      bus8.strike = 1'b1; bus8.strikeVelX = 11'sd3; bus8.strikeVelY = 11'sd0;
      tick();
      bus8.strike = 1'b0;
      for (int i = 0; i < 8; i++) sof();
      chk("p8_vx_hold", bus8.velX, 3);
      chk("p8_x_hold", bus8.topLeftX, 321);
      sof();
      chk("p8_vx_decay", bus8.velX, 2);
      chk("p8_mov", bus8.ballMoving, 1);
      chk("idle_no_move", bus.topLeftX, 320);

      // strike launch
      do_strike(32, -16);
      chk("pre_sof_vx", bus.velX, 0);
      sof();
      chk("stk_vx", bus.velX, 32);
      chk("stk_vy", bus.velY, -16);
      chk("stk_x", bus.topLeftX, 322);
      chk("stk_y", bus.topLeftY, 239);
      chk("stk_mov", bus.ballMoving, 1);

      // pocket wins over a pending collision
      do_col(7, 7);
      pulse_pocket();
      sof();
      chk("pkt_state", bus.ballPocketed, 1);
      chk("pkt_mov", bus.ballMoving, 0);
      chk("pkt_vx", bus.velX, 0);
      chk("pkt_x_frozen", bus.topLeftX, 322);
      do_strike(10, 10);
      sof();
      chk("pkt_stk_ign", bus.velX, 0);
      chk("pkt_still", bus.ballPocketed, 1);
      pulse_respawn();
      sof();
      chk("rsp_pkt", bus.ballPocketed, 0);
      chk("rsp_mov", bus.ballMoving, 0);
      chk("rsp_x", bus.topLeftX, 320);
      chk("rsp_y", bus.topLeftY, 240);

      // friction every frame: 2 -> 1 -> 0
      do_strike(2, 0);
      sof();
      chk("fr_v2", bus.velX, 2);
      sof();
      chk("fr_v1", bus.velX, 1);
      chk("fr_mov1", bus.ballMoving, 1);
      sof();
      chk("fr_v0", bus.velX, 0);
      chk("fr_idle", bus.ballMoving, 0);

      // two collisions in one frame: first wins
      do_strike(40, 0);
      sof();
      do_col(5, 5);
      do_col(-9, 0);
      sof();
      chk("col1_vx", bus.velX, 5);
      chk("col1_vy", bus.velY, 5);
      chk("col1_x", bus.topLeftX, 323);

      // collision coincident with SOF is deferred a frame
      bus.collisionOccurred = 1'b1; bus.velXIn = 11'sd20; bus.velYIn = -11'sd3;
      sof();
      bus.collisionOccurred = 1'b0;
      chk("coinc_vx", bus.velX, 4);
      chk("coinc_vy", bus.velY, 4);
      sof();
      chk("defer_vx", bus.velX, 20);
      chk("defer_vy", bus.velY, -3);
      chk("defer_x", bus.topLeftX, 324);
      chk("defer_y", bus.topLeftY, 240);

      // large strike, clamp depends on build
      pulse_pocket();
      sof();
      pulse_respawn();
      sof();
      do_strike(1000, -1000);
      sof();
`ifdef BALL_MOTION_SPEED_CLAMP_EN
      chk("big_vx", bus.velX, 256);
      chk("big_vy", bus.velY, -256);
      chk("big_x", bus.topLeftX, 336);
      chk("big_y", bus.topLeftY, 224);
`else
      chk("big_vx", bus.velX, 1000);
      chk("big_vy", bus.velY, -1000);
      chk("big_x", bus.topLeftX, 382);
      chk("big_y", bus.topLeftY, 177);
`endif
      // strike while moving is dropped; friction applies instead
      do_strike(1, 1);
      sof();
`ifdef BALL_MOTION_SPEED_CLAMP_EN
      chk("mov_stk_ign", bus.velX, 255);
`else
      chk("mov_stk_ign", bus.velX, 999);
`endif

      // reset mid-frame drops pending latches
      do_col(3, 3);
      pulse_pocket();
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      chk("mid_rst_x", bus.topLeftX, 320);
      chk("mid_rst_mov", bus.ballMoving, 0);
      sof();
      chk("mid_rst_pkt", bus.ballPocketed, 0);
      chk("mid_rst_mov2", bus.ballMoving, 0);
      chk("mid_rst_vx", bus.velX, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
